multi_voice_tone_reader: RTL
============================

# multi_voice_tone_reader

Parametrised successor to the single-voice RAM tone reader. It polls a block of CPU-shared RAM on port B and generates NUM_VOICES independent square waves, one per note word. It also mixes the waves into one 1-bit sigma-delta output for the audio pin. It sits between the CPU's data RAM port B and the sound output / seven-segment debug display.

## Interface
Parameters:
- NUM_VOICES, 4, number of voices (1..8)
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 16, RAM word width; bit DATA_WIDTH-1 = enable, low bits = half-period in clocks
- BASE_ADDR, 16'h0400, address of voice 0's note word; voice i at BASE_ADDR+i
- RAM_LATENCY, 1, clocks from read issue to valid ram_data (1..3)
- REFRESH_CYCLES, 1024, scan interval in clocks; must exceed NUM_VOICES*(RAM_LATENCY+1)+2

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high
- ram_addr  out  ADDR_WIDTH  port-B read address
- ram_rd  out  1  read strobe, one cycle per word
- ram_data  in  DATA_WIDTH  port-B read data
- voice_wave  out  NUM_VOICES  per-voice square wave
- voice_active  out  NUM_VOICES  per-voice enable bitmap (feeds Key_Pressed display)
- mix_out  out  1  sigma-delta mix of active waves
- scan_done  out  1  one-cycle pulse after each full scan

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE -> ISSUE on refresh-counter wrap. The first scan starts the cycle after reset deasserts.
- ISSUE: ram_addr = BASE_ADDR+idx, ram_rd = 1 for exactly one cycle, then -> WAIT.
- WAIT: lasts RAM_LATENCY-1 cycles, zero cycles when RAM_LATENCY = 1.
- CAPTURE: latch ram_data into voice idx's pending register.
  - If idx = NUM_VOICES-1 -> DONE; otherwise idx++ and -> ISSUE.
- DONE: scan_done = 1, idx = 0 -> IDLE.
- Refresh counter: free-running 0..REFRESH_CYCLES-1. A wrap that arrives while not in IDLE is dropped.
- Voice behaviour:
  - Enabled when enable bit = 1 and half-period P != 0. Otherwise disabled: wave forced 0, counter held at 0.
  - Counter runs 0..P-1. At P-1 the wave toggles and the counter returns to 0, giving a full period of 2P clocks.
  - A new P on an already-enabled voice takes effect only at the next toggle (glitch-free).
  - Disabled -> enabled: counter starts at 0 with wave low on the cycle after CAPTURE.
  - voice_active updates in the cycle after CAPTURE.
- Mixer:
  - sum = popcount(voice_wave & voice_active), range 0..NUM_VOICES.
  - Accumulator is clog2(NUM_VOICES)+2 bits; a = acc + sum.
  - mix_out <= (a >= NUM_VOICES); acc <= a - (mix? NUM_VOICES : 0).
  - Invariant acc < NUM_VOICES, so mix_out duty = sum/NUM_VOICES exactly.

## Timing
- Reset values:
  - ram_addr = BASE_ADDR; ram_rd = 0; scan_done = 0.
  - voice_wave = 0; voice_active = 0; mix_out = 0.
  - acc = 0; FSM = IDLE; idx = 0; refresh counter = 0.
- Each voice read takes RAM_LATENCY+1 clocks.
- A full scan takes NUM_VOICES*(RAM_LATENCY+1)+1 clocks from the first ISSUE to the scan_done pulse.
- ram_data is sampled on the edge RAM_LATENCY clocks after the ISSUE cycle's edge.
- mix_out lags voice_wave by one clock.
- Reset mid-scan aborts the scan and discards partial captures. The next scan restarts at voice 0 the cycle after reset drops.
- All outputs are registered.

## Structure
- Shared package tone_pkg holds:
  - FSM state enum;
  - enable bit index and period-field width derived from DATA_WIDTH;
  - the popcount function.
- Sub-module tone_voice: pending/active period registers, counter and toggle. Instantiated NUM_VOICES times via generate.
- FSM, refresh counter and mixer live in the top.

## Test plan
- Word 16'h8004 at BASE_ADDR, other voices 0, NUM_VOICES=4 -> voice_wave[0] toggles every 4 clocks (period 8). voice_active = 4'b0001; mix_out duty 1/8 averaged over 32 clocks.
- RAM_LATENCY=2, NUM_VOICES=4 -> ram_rd pulses at 3-clock spacing on addresses 0x0400..0x0403; scan_done pulses 13 clocks after the first ISSUE.
- Change voice 0 from 16'h8004 to 16'h8002 mid-period -> the current 4-clock half-period completes, then the wave toggles every 2 clocks with no short pulse.
- All four voices 16'h8001 -> all waves toggle every clock in phase. mix_out alternates between constant 1 and constant 0 runs matching sum 4/0.
- Voice word 16'h8000 (enabled, P=0) and 16'h0005 -> both voices remain wave 0 and active 0.
- Assert reset during the CAPTURE of voice 2 -> all outputs return to reset values next clock. The next scan reissues address 0x0400.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared definitions for the multi-voice tone reader.
//   tone_state_t  : scan FSM states (also driven out on the debug port)
//   enable_bit()  : bit index of the voice enable flag inside a note word
//   period_width(): width of the half-period field below the enable flag
//   popcount()    : number of set bits in a voice bitmap (up to MAX_VOICES)
package tone_pkg;

  localparam int MAX_VOICES = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } tone_state_t;

  function automatic int enable_bit(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int period_width(input int data_width);
    return data_width - 1;
  endfunction

  function automatic logic [3:0] popcount(input logic [MAX_VOICES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_VOICES; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice.
//   clock, reset : system clock, synchronous active-high reset
//   i_load       : one-cycle strobe, i_word is a freshly read note word
//   i_word       : note word (enable flag in the MSB, half-period below)
//   o_wave       : square wave, half-period = programmed P clocks
//   o_active     : voice is enabled with a non-zero period
module tone_voice
  import tone_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic                  o_wave,
  output logic                  o_active
);

  localparam int EN_BIT = enable_bit(DATA_WIDTH);
  localparam int PW     = period_width(DATA_WIDTH);
  localparam logic [PW-1:0] PER_ONE = PW'(1);

  logic [PW-1:0] r_pend_p;   // most recently read period
  logic [PW-1:0] r_per;      // period of the half-cycle in progress
  logic [PW-1:0] r_cnt;
  logic          r_active;
  logic          r_wave;

  logic [PW-1:0] w_word_p;
  logic          w_word_en;

  assign w_word_p  = i_word[PW-1:0];
  assign w_word_en = i_word[EN_BIT] && (w_word_p != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_p <= '0;
      r_per    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_wave   <= 1'b0;
    end else begin
      if (i_load) r_pend_p <= w_word_p;
      if (i_load && !w_word_en) begin
        r_active <= 1'b0;
        r_wave   <= 1'b0;
        r_cnt    <= '0;
      end else if (i_load && !r_active) begin
        // Fresh start: low phase begins with counter at 0.
        r_active <= 1'b1;
        r_per    <= w_word_p;
        r_cnt    <= '0;
        r_wave   <= 1'b0;
      end else if (r_active) begin
        if (r_cnt == r_per - PER_ONE) begin
          // A new period is picked up only here, so no half-cycle is cut short.
          // A load on this same edge is seen from the next toggle on.
          r_wave <= ~r_wave;
          r_cnt  <= '0;
          r_per  <= r_pend_p;
        end else begin
          r_cnt <= r_cnt + PER_ONE;
        end
      end
    end
  end

  assign o_wave   = r_wave;
  assign o_active = r_active;

endmodule

// File: rtl/multi_voice_tone_reader.sv
// Polls NUM_VOICES note words from shared RAM port B and plays them as square
// waves, plus a 1-bit sigma-delta mix of all active waves.
//   clock, reset  : system clock, synchronous active-high reset
//   ram_addr      : port-B read address (BASE_ADDR + voice index)
//   ram_rd        : read strobe, high for exactly one cycle per word
//   ram_data      : read data, valid RAM_LATENCY clocks after the strobe
//   voice_wave    : per-voice square waves
//   voice_active  : per-voice enable bitmap
//   mix_out       : sigma-delta mix, duty = active high waves / NUM_VOICES
//   scan_done     : one-cycle pulse after every completed scan
//   dbg_state     : current scan FSM state
// RAM handshake: there is no ready; a read is a single-cycle ram_rd with
// ram_addr held, and the RAM guarantees ram_data on the edge RAM_LATENCY
// clocks after the edge that sampled ram_rd.
module multi_voice_tone_reader
  import tone_pkg::*;
#(
  parameter int                    NUM_VOICES     = 4,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0400,
  parameter int                    RAM_LATENCY    = 1,
  parameter int                    REFRESH_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rd,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [NUM_VOICES-1:0] voice_wave,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  mix_out,
  output logic                  scan_done,
  output tone_state_t           dbg_state
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RC_W  = $clog2(REFRESH_CYCLES);
  localparam int ACC_W = $clog2(NUM_VOICES) + 2;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(REFRESH_CYCLES - 1);
  localparam logic [1:0]       WAIT_INIT = 2'((RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0);
  localparam logic [ACC_W-1:0] ACC_N     = ACC_W'(NUM_VOICES);

  tone_state_t           r_state, w_next_state;
  logic [IDX_W-1:0]      r_idx, w_next_idx;
  logic [1:0]            r_wait, w_next_wait;
  logic [RC_W-1:0]       r_refresh;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_rd;
  logic                  r_scan_done;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_mix;

  logic                  w_tick;
  logic [NUM_VOICES-1:0] w_load;
  logic [NUM_VOICES-1:0] w_wave;
  logic [NUM_VOICES-1:0] w_active;
  logic [3:0]            w_sum;
  logic [ACC_W-1:0]      w_a;
  logic                  w_mix;

  // The counter sits at 0 right after reset, so the first scan starts at once.
  // Ticks seen outside IDLE are simply ignored by the FSM.
  assign w_tick = (r_refresh == '0);

  always_ff @(posedge clock) begin
    if (reset) r_refresh <= '0;
    else if (r_refresh == RC_LAST) r_refresh <= '0;
    else r_refresh <= r_refresh + RC_W'(1);
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_wait  = r_wait;
    case (r_state)
      ST_IDLE: if (w_tick) w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (RAM_LATENCY == 1) begin
          w_next_state = ST_CAPTURE;
        end else begin
          w_next_state = ST_WAIT;
          w_next_wait  = WAIT_INIT;
        end
      end
      ST_WAIT: begin
        if (r_wait == 2'd0) w_next_state = ST_CAPTURE;
        else w_next_wait = r_wait - 2'd1;
      end
      ST_CAPTURE: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_idx   = r_idx + IDX_W'(1);
          w_next_state = ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_next_idx   = '0;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait      <= '0;
      r_ram_addr  <= BASE_ADDR;
      r_ram_rd    <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_wait      <= w_next_wait;
      // Registered from next-state so the strobe lines up with ISSUE.
      r_ram_rd    <= (w_next_state == ST_ISSUE);
      if (w_next_state == ST_ISSUE) r_ram_addr <= BASE_ADDR + ADDR_WIDTH'(w_next_idx);
      // Pulse lands in the cycle after DONE.
      r_scan_done <= (r_state == ST_DONE);
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign w_load[gi] = (r_state == ST_CAPTURE) && (r_idx == IDX_W'(gi));
    tone_voice #(.DATA_WIDTH(DATA_WIDTH)) u_voice (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_load[gi]),
      .i_word   (ram_data),
      .o_wave   (w_wave[gi]),
      .o_active (w_active[gi])
    );
  end

  // First-order sigma-delta; acc stays below NUM_VOICES so the duty is exact.
  assign w_sum = popcount(MAX_VOICES'(w_wave & w_active));
  assign w_a   = r_acc + ACC_W'(w_sum);
  assign w_mix = (w_a >= ACC_N);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
      r_mix <= 1'b0;
    end else begin
      r_mix <= w_mix;
      r_acc <= w_mix ? (w_a - ACC_N) : w_a;
    end
  end

  assign ram_addr     = r_ram_addr;
  assign ram_rd       = r_ram_rd;
  assign scan_done    = r_scan_done;
  assign voice_wave   = w_wave;
  assign voice_active = w_active;
  assign mix_out      = r_mix;
  assign dbg_state    = r_state;

endmodule
